// File: rtl/fetch_redirect_ctrl_pkg.sv
// rtl/fetch_redirect_ctrl_pkg.sv - shared fetch-redirect types and constants
package fetch_redirect_ctrl_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
   localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

   typedef struct packed {
      logic        valid;
      logic [31:0] target;
   } redirect_t;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - EXE/WB redirect inputs and instruction-fetch port
interface fetch_redirect_ctrl_if;

   logic        EXE_Branch_Flush;
   logic        EXE_Delayslot_Flush;
   logic [31:0] EXE_BranchTarget;
   logic        EXE_Stall;
   logic        WB_Exc_Redirect;
   logic [31:0] WB_Exc_PC;
   logic        IF_Ready;
   logic        IF_RespValid;
   logic [31:0] PC;
   logic        IF_ReqValid;
   logic        IF_RespDrop;
   logic        IFID_Flush;
   logic        IDEXE_Flush;

   // Pipeline / fetch-port side that drives the redirect controller
   modport master (
      output EXE_Branch_Flush, EXE_Delayslot_Flush, EXE_BranchTarget, EXE_Stall,
      output WB_Exc_Redirect, WB_Exc_PC, IF_Ready, IF_RespValid,
      input  PC, IF_ReqValid, IF_RespDrop, IFID_Flush, IDEXE_Flush
   );

   modport slave (
      input  EXE_Branch_Flush, EXE_Delayslot_Flush, EXE_BranchTarget, EXE_Stall,
      input  WB_Exc_Redirect, WB_Exc_PC, IF_Ready, IF_RespValid,
      output PC, IF_ReqValid, IF_RespDrop, IFID_Flush, IDEXE_Flush
   );

endinterface

// File: rtl/fetch_redirect_ctrl_redirect_arb.sv
// rtl/fetch_redirect_ctrl_redirect_arb.sv - exc > br > ds priority decode and flush bits
module redirect_arb
   import fetch_redirect_ctrl_pkg::*;
(
   input  logic        exc_i,
   input  logic [31:0] exc_pc_i,
   input  logic        br_flush_i,
   input  logic [31:0] br_target_i,
   input  logic        ds_flush_i,
   input  logic        stall_i,
   output redirect_t   redir_o,
   output logic        ifid_flush_o,
   output logic        idexe_flush_o
);

   logic br;
   logic ds;

   // A stalled EXE has not really resolved its branch yet; WB exceptions are never held off
   always_comb begin
      br             = br_flush_i & ~stall_i & ~exc_i;
      ds             = ds_flush_i & ~stall_i & ~exc_i & ~br;
      redir_o.valid  = exc_i | br;
      redir_o.target = exc_i ? exc_pc_i : br_target_i;
      ifid_flush_o   = exc_i | br;
      idexe_flush_o  = exc_i | ds;
   end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch PC owner; turns redirects into new PC, kills and response drops
module fetch_redirect_ctrl
   import fetch_redirect_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
)
(
   input  logic                 clk,
   input  logic                 rst,
   fetch_redirect_ctrl_if.slave bus
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         inflight_q, inflight_d;

   redirect_t    redir;
   logic         ifid_flush;
   logic         idexe_flush;
   logic         req_valid;
   logic         accept;
   logic         resp_pending;

   redirect_arb u_arb (
      .exc_i         (bus.WB_Exc_Redirect),
      .exc_pc_i      (bus.WB_Exc_PC),
      .br_flush_i    (bus.EXE_Branch_Flush),
      .br_target_i   (bus.EXE_BranchTarget),
      .ds_flush_i    (bus.EXE_Delayslot_Flush),
      .stall_i       (bus.EXE_Stall),
      .redir_o       (redir),
      .ifid_flush_o  (ifid_flush),
      .idexe_flush_o (idexe_flush)
   );

   always_comb begin
      // A returning response frees the single slot in time for a back-to-back request
      req_valid    = ~rst & (state_q == RUN) & (~inflight_q | bus.IF_RespValid);
      accept       = req_valid & bus.IF_Ready;
      resp_pending = inflight_q & ~bus.IF_RespValid;
      inflight_d   = accept | resp_pending;
      state_d      = state_q;
      pc_d         = pc_q;
      unique case (state_q)
         RUN: begin
            if (redir.valid) begin
               pc_d = redir.target;
               if (accept | resp_pending) begin
                  state_d = DRAIN;
               end
            end else if (accept) begin
               pc_d = pc_q + PC_STEP;
            end
         end
         DRAIN: begin
            if (redir.valid) begin
               pc_d = redir.target;
            end
            // The only outstanding request is wrong-path, so its return ends the drain
            if (bus.IF_RespValid) begin
               state_d = RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
      end
   end

   assign bus.PC          = pc_q;
   assign bus.IF_ReqValid = req_valid;
   assign bus.IF_RespDrop = ~rst & bus.IF_RespValid & (redir.valid | (state_q == DRAIN));
   assign bus.IFID_Flush  = ~rst & ifid_flush;
   assign bus.IDEXE_Flush = ~rst & idexe_flush;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed and random checks of fetch_redirect_ctrl against a request-queue model
module tb_fetch_redirect_ctrl;

   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   logic clk;
   logic rst;
   fetch_redirect_ctrl_if bus ();

   fetch_redirect_ctrl #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   logic [31:0] mpc;
   bit          pc_known = 0;
   bit          wq[$];   // outstanding requests; 1 = wrong-path

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit r, input bit exc, input logic [31:0] epc,
                       input bit br, input logic [31:0] bt, input bit ds,
                       input bit stall, input bit rdy, input bit resp);
      bit e_br, e_ds, ev, any_wrong, e_req, e_drop, acc;
      @(negedge clk);
      rst                     = r;
      bus.WB_Exc_Redirect     = exc;
      bus.WB_Exc_PC           = epc;
      bus.EXE_Branch_Flush    = br;
      bus.EXE_BranchTarget    = bt;
      bus.EXE_Delayslot_Flush = ds;
      bus.EXE_Stall           = stall;
      bus.IF_Ready            = rdy;
      bus.IF_RespValid        = resp;
      #4;
      if (r) begin
         chk("rst_req",   {31'd0, bus.IF_ReqValid}, 32'd0);
         chk("rst_drop",  {31'd0, bus.IF_RespDrop}, 32'd0);
         chk("rst_ifid",  {31'd0, bus.IFID_Flush},  32'd0);
         chk("rst_idexe", {31'd0, bus.IDEXE_Flush}, 32'd0);
         wq.delete();
         mpc      = RST_PC;
         pc_known = 1;
      end else begin
         e_br      = br & ~stall & ~exc;
         e_ds      = ds & ~stall & ~exc & ~e_br;
         ev        = exc | e_br;
         any_wrong = 0;
         foreach (wq[i]) if (wq[i]) any_wrong = 1;
         e_req     = !any_wrong && (wq.size() == 0 || resp);
         e_drop    = resp && (ev || (wq.size() > 0 && wq[0]));
         if (pc_known) chk("pc", bus.PC, mpc);
         chk("req_valid", {31'd0, bus.IF_ReqValid}, {31'd0, e_req});
         chk("resp_drop", {31'd0, bus.IF_RespDrop}, {31'd0, e_drop});
         chk("ifid",      {31'd0, bus.IFID_Flush},  {31'd0, ev});
         chk("idexe",     {31'd0, bus.IDEXE_Flush}, {31'd0, exc | e_ds});
         if (resp && wq.size() > 0) void'(wq.pop_front());
         if (ev) foreach (wq[i]) wq[i] = 1;
         acc = e_req && rdy;
         if (acc) wq.push_back(ev);
         if (exc)       mpc = epc;
         else if (e_br) mpc = bt;
         else if (acc)  mpc = mpc + 32'd4;
      end
      @(posedge clk);
   endtask

   initial begin
      rst = 1'b1;
      bus.WB_Exc_Redirect = 0; bus.WB_Exc_PC = 0; bus.EXE_Branch_Flush = 0;
      bus.EXE_BranchTarget = 0; bus.EXE_Delayslot_Flush = 0; bus.EXE_Stall = 0;
      bus.IF_Ready = 0; bus.IF_RespValid = 0;

      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 32'h1234, 1, 32'h5678, 1, 0, 1, 1);

      // sequential fetch
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1 chk("t1_pc1", bus.PC, 32'hBFC0_0004);
      for (int i = 2; i <= 4; i++) begin
         step(0, 0, 0, 0, 0, 0, 0, 1, 1);
         #1 chk("t1_pc", bus.PC, RST_PC + 32'(4 * i));
      end

      // taken branch with request accepted the same cycle
      step(0, 0, 0, 1, 32'h8000_1000, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      #1 chk("t2_pc", bus.PC, 32'h8000_1000);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);

      // delay-slot kill only
      step(0, 0, 0, 0, 0, 1, 0, 1, 1);
      #1 chk("t3_pc", bus.PC, 32'h8000_1008);

      // exception beats branch
      step(0, 1, 32'hBFC0_0380, 1, 32'h8000_2000, 0, 0, 0, 1);
      #1 chk("t4_pc", bus.PC, 32'hBFC0_0380);

      // stalled branch resolves in the first unstalled cycle
      step(0, 0, 0, 1, 32'h8000_4000, 0, 1, 1, 0);
      step(0, 0, 0, 1, 32'h8000_4000, 0, 1, 1, 1);
      step(0, 0, 0, 1, 32'h8000_4000, 0, 0, 0, 1);
      #1 chk("t5_pc", bus.PC, 32'h8000_4000);

      // second branch while draining wins
      step(0, 0, 0, 1, 32'h8000_1100, 0, 0, 1, 0);
      step(0, 0, 0, 1, 32'h8000_3000, 1, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      #1 chk("t6_pc", bus.PC, 32'h8000_3000);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);

      // reset in the middle of a drain
      step(0, 0, 0, 1, 32'h8000_1200, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1 chk("t7_pc", bus.PC, RST_PC);

      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 15) == 0, {$urandom, 2'b00} >> 2 << 2,
              $urandom_range(0, 5) == 0, $urandom & 32'hFFFF_FFFC,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) != 0,
              (wq.size() > 0) && ($urandom_range(0, 1) == 1));
      end

      // PC wrap at the top of the address space
      step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, wq.size() > 0);
      while (wq.size() > 0) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1 chk("wrap_pc", bus.PC, 32'h0000_0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
